// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of {pc, inst} between fetch and decode.
// Define FETCH_BUF_BYPASS_EN to forward a push straight to decode when the buffer is empty.
module fetch_buffer #(
  parameter int ADDR  = 16,
  parameter int WORD  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       v_i,
  input  logic [ADDR-1:0]            pc_i,
  input  logic [WORD-1:0]            inst_i,
  output logic                       stall_o,
  output logic                       v_o,
  output logic [ADDR-1:0]            pc_o,
  output logic [WORD-1:0]            inst_o,
  input  logic                       stall_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR-1:0] r_pc [DEPTH];
  logic [WORD-1:0] r_inst [DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [PW:0]     r_cnt;
  logic            w_full, w_nemp, w_byp, w_push, w_pop;
  assign w_full = r_cnt == (PW+1)'(DEPTH);
  assign w_nemp = r_cnt != '0;
`ifdef FETCH_BUF_BYPASS_EN
  assign w_byp = ~w_nemp & v_i & ~flush_i;
`else
  assign w_byp = 1'b0;
`endif
  // A bypassed entry that decode takes immediately is never stored.
  assign w_push  = v_i & ~w_full & ~flush_i & ~(w_byp & ~stall_i);
  assign w_pop   = w_nemp & ~stall_i & ~flush_i;
  assign stall_o = w_full;
  assign v_o     = w_nemp | w_byp;
  assign count_o = r_cnt;
`ifdef FETCH_BUF_BYPASS_EN
  assign pc_o   = w_nemp ? r_pc[r_rp] : w_byp ? pc_i : '0;
  assign inst_o = w_nemp ? r_inst[r_rp] : w_byp ? inst_i : '0;
`else
  assign pc_o   = w_nemp ? r_pc[r_rp] : '0;
  assign inst_o = w_nemp ? r_inst[r_rp] : '0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) begin
      r_pc[r_wp]   <= pc_i;
      r_inst[r_wp] <= inst_i;
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with a reference count model and a scoreboard queue drained by a monitor.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 1, flush_i = 0, v_i = 0, stall_i = 1;
  logic [15:0] pc_i = '0, pc_o;
  logic [31:0] inst_i = '0, inst_o;
  logic        stall_o, v_o;
  logic [2:0]  count_o;
  int          n_chk = 0, n_fail = 0;
  int          mcnt = 0, mnext = 0;
  bit          exp_v = 0;
  logic [47:0] q[$];

  fetch_buffer #(.ADDR(16), .WORD(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .v_i(v_i), .pc_i(pc_i), .inst_i(inst_i),
    .stall_o(stall_o), .v_o(v_o), .pc_o(pc_o), .inst_o(inst_o), .stall_i(stall_i), .count_o(count_o));

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(logic [15:0] pc);
    return 32'hDEAD_0000 ^ (32'(pc) * 32'd7);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit v, logic [15:0] pc, bit st, bit fl);
    bit byp, push, pop;
    @(posedge clk);
    #1;
    mcnt    = mnext;
    v_i     = v;
    pc_i    = v ? pc : 16'($urandom);
    inst_i  = v ? inst_of(pc) : $urandom;
    stall_i = st;
    flush_i = fl;
    byp = 0;
`ifdef FETCH_BUF_BYPASS_EN
    byp = (mcnt == 0) && v && !fl;
`endif
    exp_v = (mcnt != 0) || byp;
    push  = v && (mcnt < DEPTH) && !fl;
    pop   = exp_v && !st && !fl;
    if (fl) q.delete();
    else if (push) q.push_back({pc, inst_of(pc)});
    mnext = fl ? 0 : mcnt + int'(push) - int'(pop);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("count_o", 64'(count_o), 64'(mcnt));
      chk("stall_o", 64'(stall_o), 64'(mcnt == DEPTH));
      chk("v_o", 64'(v_o), 64'(exp_v));
      if (v_o && !stall_i && !flush_i) begin
        if (q.size() == 0) chk("unexpected_pop", 64'(pc_o), 64'hFFFF_FFFF_FFFF);
        else begin
          logic [47:0] e;
          e = q.pop_front();
          chk("pc_o", 64'(pc_o), 64'(e[47:32]));
          chk("inst_o", 64'(inst_o), 64'(e[31:0]));
        end
      end else if (!v_o) begin
        chk("pc_o_idle", 64'(pc_o), 64'd0);
        chk("inst_o_idle", 64'(inst_o), 64'd0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_pc", 64'(pc_o), 64'd0);
    @(posedge clk);
    #1 reset = 0;
    // fill while decode stalls, then a rejected fifth push
    for (int i = 0; i < 4; i++) step(1, 16'(i), 1, 0);
    step(1, 16'd4, 1, 0);
    // one-cycle decode release while full: pop pc 0, push still rejected
    step(1, 16'd4, 0, 0);
    step(0, 16'd0, 1, 0);
    repeat (4) step(0, 16'd0, 0, 0);
    // continuous stream
    for (int i = 0; i < 10; i++) step(1, 16'(i), 0, 0);
    repeat (2) step(0, 16'd0, 0, 0);
    // flush with a concurrent push
    for (int i = 0; i < 3; i++) step(1, 16'(16'h20 + i), 1, 0);
    step(1, 16'h40, 0, 1);
    repeat (2) step(0, 16'd0, 0, 0);
    // asynchronous reset between edges with two entries held
    step(1, 16'h31, 1, 0);
    step(1, 16'h32, 1, 0);
    step(0, 16'd0, 1, 0);
    #2 reset = 1;
    #1;
    chk("arst_v", 64'(v_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_pc", 64'(pc_o), 64'd0);
    chk("arst_inst", 64'(inst_o), 64'd0);
    chk("arst_stall", 64'(stall_o), 64'd0);
    q.delete();
    mcnt = 0; mnext = 0; exp_v = 0;
    @(posedge clk);
    #1 reset = 0;
    step(1, 16'h77, 1, 0);
    step(1, 16'h78, 1, 0);
    repeat (3) step(0, 16'd0, 0, 0);
    // push into an empty buffer with decode ready
    step(1, 16'h10, 0, 0);
    repeat (3) step(0, 16'd0, 0, 0);
    step(0, 16'd0, 1, 0);
    @(posedge clk);
    #2;
    chk("drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
